// File: rtl/sin_s11_s11.sv
// sin_s11_s11 : pipelined 12-bit phase -> signed 12-bit sine.
// One full turn is 4096 phase steps. The phase is folded onto a 1025-entry
// quarter-wave table, then the sign is restored.
// There are four register stages, and all of them advance only when CK_EE_i is 1.
// A side-band word and a valid flag travel through the same stages.

module sin_s11_s11 #(
   parameter int C_B_DAT_W = 1
) (
   input  logic                 CK_i,
   input  logic                 XARST_i,
   input  logic                 CK_EE_i,
   input  logic [C_B_DAT_W-1:0] B_IN_DAT_DLYs_i,
   input  logic [11:0]          DATs_i,
   output logic signed [11:0]   SINs_o,
   output logic                 DONE_o,
   output logic [C_B_DAT_W-1:0] B_OUT_DAT_DLYs_o
);

   // pi scaled by 2^30, used by the elaboration-time table generator
   localparam longint PI_Q30 = 64'sd3373259426;

   // Quarter-wave magnitude round(2047*sin(pi/2*i/1024)), evaluated with a
   // Q30 Taylor series (terms up to x^17). The end points are pinned exactly.
   function automatic logic [10:0] quarter_sin(input longint i);
      longint x;
      longint x2;
      longint term;
      longint acc;
      longint mag;
      if (i <= 0) return 11'd0;
      if (i >= 1024) return 11'd2047;
      x    = (PI_Q30 * i) / 2048;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (longint n = 1; n <= 8; n++) begin
         term = -((term * x2) >>> 30) / ((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      mag = (acc * 2047 + (64'sd1 <<< 29)) >>> 30;
      if (mag < 0)    mag = 0;
      if (mag > 2047) mag = 2047;
      return mag[10:0];
   endfunction

   // NOTE: the table is a constant built at elaboration; only the pipeline registers hold state and need a reset.
   logic [10:0] rom [0:1024];

   for (genvar g = 0; g <= 1024; g++) begin : g_rom
      localparam logic [10:0] ROM_V = quarter_sin(longint'(g));
      assign rom[g] = ROM_V;
   end

   // stage 1 : registered phase
   logic [11:0]          p1;
   logic [C_B_DAT_W-1:0] b1;
   logic                 v1;
   // stage 2 : folded table index and sign
   logic [10:0]          idx2;
   logic                 neg2;
   logic [C_B_DAT_W-1:0] b2;
   logic                 v2;
   // stage 3 : table magnitude and sign
   logic [10:0]          mag3;
   logic                 neg3;
   logic [C_B_DAT_W-1:0] b3;
   logic                 v3;

   // The fold mirrors quadrants 1 and 3, so idx covers 0..1024 inclusive.
   logic [10:0]        idx_c;
   logic signed [11:0] mag_s;
   logic signed [11:0] sin_c;

   assign idx_c = p1[10] ? (11'd1024 - {1'b0, p1[9:0]}) : {1'b0, p1[9:0]};
   assign mag_s = signed'({1'b0, mag3});
   // The magnitude never exceeds 2047, so negating it cannot overflow.
   assign sin_c = neg3 ? -mag_s : mag_s;

   // Stage 1: capture the phase, the side-band word and the enable.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         p1 <= '0;
         b1 <= '0;
         v1 <= 1'b0;
      end else if (CK_EE_i) begin
         // NOTE: non-blocking so every stage samples the previous stage's old value on the same edge.
         p1 <= DATs_i;
         b1 <= B_IN_DAT_DLYs_i;
         v1 <= CK_EE_i;
      end
   end

   // Stage 2: fold the phase onto the quarter-wave index and keep the half-turn sign.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         idx2 <= '0;
         neg2 <= 1'b0;
         b2   <= '0;
         v2   <= 1'b0;
      end else if (CK_EE_i) begin
         idx2 <= idx_c;
         neg2 <= p1[11];
         b2   <= b1;
         v2   <= v1;
      end
   end

   // Stage 3: look up the magnitude in the table.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         mag3 <= '0;
         neg3 <= 1'b0;
         b3   <= '0;
         v3   <= 1'b0;
      end else if (CK_EE_i) begin
         mag3 <= rom[idx2];
         neg3 <= neg2;
         b3   <= b2;
         v3   <= v2;
      end
   end

   // Stage 4: apply the sign and drive the outputs.
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         SINs_o           <= '0;
         DONE_o           <= 1'b0;
         B_OUT_DAT_DLYs_o <= '0;
      end else if (CK_EE_i) begin
         SINs_o           <= sin_c;
         DONE_o           <= v3;
         B_OUT_DAT_DLYs_o <= b3;
      end
   end

endmodule

// File: tb/tb_sin_s11_s11.sv
// tb_sin_s11_s11 : directed bench for the pipelined phase -> sine converter.
// A four-deep reference pipeline tracks phase, side-band bit and valid flag
// through the enabled clock edges. Sine values are checked against hand
// constants and against a floating-point reference.

module tb_sin_s11_s11;

   localparam int BW = 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               ee;
   logic [BW-1:0]      b_in;
   logic [11:0]        dat;
   logic signed [11:0] sin_o;
   logic               done;
   logic [BW-1:0]      b_out;

   int n_chk  = 0;
   int n_pass = 0;

   // reference pipeline, index 3 = what the outputs should show
   int mdl_ph [4];
   int mdl_b  [4];
   int mdl_v  [4];

   // observed output per phase during the full ramp
   int out_tab [4096];
   bit seen    [4096];
   bit rec = 1'b0;

   always #5 clk = ~clk;

   sin_s11_s11 #(.C_B_DAT_W(BW)) dut (
      .CK_i             (clk),
      .XARST_i          (rst_n),
      .CK_EE_i          (ee),
      .B_IN_DAT_DLYs_i  (b_in),
      .DATs_i           (dat),
      .SINs_o           (sin_o),
      .DONE_o           (done),
      .B_OUT_DAT_DLYs_o (b_out)
   );

   task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
      n_chk++;
      if ((obs - exp > tol) || (exp - obs > tol))
         $display("FAIL %s: got %0d, want %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
      else
         n_pass++;
   endtask

   function automatic int ref_sin(input int p);
      real r;
      r = 2047.0 * $sin(6.283185307179586 * real'(p) / 4096.0);
      return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < 4; i++) begin
         mdl_ph[i] = 0;
         mdl_b[i]  = 0;
         mdl_v[i]  = 0;
      end
   endtask

   // One clock cycle: drive at the falling edge, let one rising edge act,
   // then compare the outputs with the reference at the next falling edge.
   task automatic cyc(input bit e, input int ph, input int b);
      ee   = e;
      dat  = ph[11:0];
      b_in = b[BW-1:0];
      @(posedge clk);
      if (e) begin
         for (int i = 3; i > 0; i--) begin
            mdl_ph[i] = mdl_ph[i-1];
            mdl_b[i]  = mdl_b[i-1];
            mdl_v[i]  = mdl_v[i-1];
         end
         mdl_ph[0] = ph & 4095;
         mdl_b[0]  = b & ((1 << BW) - 1);
         mdl_v[0]  = 1;
      end
      @(negedge clk);
      check("done", int'(done), mdl_v[3]);
      check("bout", int'(b_out), mdl_b[3]);
      if (mdl_v[3] != 0) begin
         check($sformatf("sin_p%0d", mdl_ph[3]), int'(sin_o), ref_sin(mdl_ph[3]), 1);
         if (rec) begin
            out_tab[mdl_ph[3]] = int'(sin_o);
            seen[mdl_ph[3]]    = 1'b1;
         end
      end else begin
         check("sin_idle", int'(sin_o), 0);
      end
      check("no_min", int'(sin_o == -12'sd2048), 0);
   endtask

   int t2_ph  [7] = '{0, 256, 512, 1024, 2048, 3072, 4095};
   int t2_exp [7] = '{0, 783, 1447, 2047, 0, -2047, -3};
   int t2_tol [7] = '{0, 1, 1, 0, 0, 0, 1};

   initial begin
      int hold_sin;
      int hold_done;
      int hold_b;
      int n_seen;

      rst_n = 1'b0;
      ee    = 1'b1;
      dat   = '0;
      b_in  = '0;
      mdl_clear();

      // Reset state, then the DONE start-up sequence with phase 0.
      repeat (3) @(negedge clk);
      check("rst_sin", int'(sin_o), 0);
      check("rst_done", int'(done), 0);
      check("rst_bout", int'(b_out), 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cyc(1'b1, 0, 0);
         check($sformatf("t1_done_c%0d", k), int'(done), (k >= 4) ? 1 : 0);
         check($sformatf("t1_sin_c%0d", k), int'(sin_o), 0);
      end

      // Directed sweep of key phases, with results read back in order.
      for (int i = 0; i < 11; i++) begin
         cyc(1'b1, (i < 7) ? t2_ph[i] : 0, 0);
         if (i >= 3 && i < 10)
            check($sformatf("t2_ph%0d", t2_ph[i-3]), int'(sin_o), t2_exp[i-3], t2_tol[i-3]);
      end

      // Full ramp with a toggling side-band bit and a 10-cycle enable gap.
      rec = 1'b1;
      for (int p = 0; p < 4096; p++) begin
         if (p == 1500) begin
            hold_sin  = int'(sin_o);
            hold_done = int'(done);
            hold_b    = int'(b_out);
            repeat (10) begin
               cyc(1'b0, int'($urandom_range(4095)), int'($urandom_range(1)));
               check("hold_sin", int'(sin_o), hold_sin);
               check("hold_done", int'(done), hold_done);
               check("hold_bout", int'(b_out), hold_b);
            end
         end
         cyc(1'b1, p, p & 1);
      end
      repeat (4) cyc(1'b1, 0, 0);
      rec = 1'b0;

      n_seen = 0;
      for (int p = 0; p < 4096; p++) n_seen += int'(seen[p]);
      check("ramp_cnt", n_seen, 4096);
      check("ramp_q1", out_tab[1024], 2047);
      check("ramp_q3", out_tab[3072], -2047);
      check("ramp_z0", out_tab[0], 0);
      check("ramp_z2048", out_tab[2048], 0);
      for (int p = 0; p < 2048; p++)
         check($sformatf("sym_neg_p%0d", p), out_tab[p], -out_tab[p + 2048]);
      for (int k = 1; k < 1024; k++)
         check($sformatf("sym_mir_k%0d", k), out_tab[1024 - k], out_tab[1024 + k]);
      for (int p = 0; p < 1024; p++)
         check($sformatf("mono_p%0d", p), int'(out_tab[p + 1] < out_tab[p]), 0);

      // Asynchronous reset in the middle of a stream, then restart.
      for (int p = 0; p < 30; p++) cyc(1'b1, p * 37, p & 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_sin", int'(sin_o), 0);
      check("arst_done", int'(done), 0);
      check("arst_bout", int'(b_out), 0);
      mdl_clear();
      @(posedge clk);
      @(negedge clk);
      check("arst_hold_sin", int'(sin_o), 0);
      check("arst_hold_done", int'(done), 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b1, 100 + k * 200, k & 1);
         check($sformatf("t6_done_c%0d", k), int'(done), (k >= 4) ? 1 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
